// File: rtl/spram32_bctl.sv
// Byte-addressed load/store controller in front of the 32K x 32 single-port RAM.
// Define SPRAM32_SPLIT_EN to split word-crossing accesses; otherwise they complete with err.
module spram32_bctl #(
    parameter int unsigned ASZ = 15,
    parameter int unsigned DSZ = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req,
    input  logic           we,
    input  logic [ASZ+1:0] addr,
    input  logic [1:0]     sz,
    input  logic           sx,
    input  logic [DSZ-1:0] wdata,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [DSZ-1:0] rdata,
    output logic [ASZ-1:0] m_ai,
    output logic           m_we,
    output logic [3:0]     m_bmsk,
    output logic [DSZ-1:0] m_vi,
    input  logic [DSZ-1:0] m_vo
);

    typedef enum logic [2:0] {StIdle, StAcc0, StAcc1, StRcap, StFin} state_e;

    state_e state_q, state_d;

    logic           we_q, sx_q, split_q;
    logic [1:0]     off_q, sz_q;
    logic [3:0]     bmhi_q;
    logic [DSZ-1:0] dhi_q, lo_q, rdata_q;

    logic [ASZ-1:0] m_ai_q, m_ai_d;
    logic           m_we_q, m_we_d;
    logic [3:0]     m_bmsk_q, m_bmsk_d;
    logic [DSZ-1:0] m_vi_q, m_vi_d;

    logic [1:0]       in_off;
    logic [3:0]       in_nm;
    logic [7:0]       in_bm8;
    logic [2*DSZ-1:0] in_d64;
    logic             in_split;

    logic [2*DSZ-1:0] rd64;
    logic [DSZ-1:0]   rd_sh, rd_ext;

`ifdef SPRAM32_SPLIT_EN
    localparam bit SplitEn = 1'b1;
    assign err = 1'b0;
`else
    localparam bit SplitEn = 1'b0;
    logic xerr_q;

    // Remembers that the accepted request crossed a word and was refused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xerr_q <= 1'b0;
        end else if (state_q == StIdle && req) begin
            xerr_q <= in_split;
        end
    end

    assign err = done & xerr_q;
`endif

    // Lane mask and lane-aligned store data over the two words an access may touch.
    always_comb begin
        in_off = addr[1:0];
        case (sz)
            2'd0:    in_nm = 4'b0001;
            2'd1:    in_nm = 4'b0011;
            default: in_nm = 4'b1111;
        endcase
        in_bm8   = {4'b0000, in_nm} << in_off;
        in_d64   = {{DSZ{1'b0}}, wdata} << {in_off, 3'b000};
        in_split = |in_bm8[7:4];
    end

    // Low word comes from the ACC0 beat; for unsplit loads it is on m_vo right now.
    always_comb begin
        rd64  = {m_vo, split_q ? lo_q : m_vo};
        rd_sh = DSZ'(rd64 >> {off_q, 3'b000});
        case (sz_q)
            2'd0:    rd_ext = {{(DSZ-8){sx_q & rd_sh[7]}}, rd_sh[7:0]};
            2'd1:    rd_ext = {{(DSZ-16){sx_q & rd_sh[15]}}, rd_sh[15:0]};
            default: rd_ext = rd_sh;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = (!SplitEn && in_split) ? StFin : StAcc0;
                end
            end
            StAcc0:  state_d = split_q ? StAcc1 : (we_q ? StFin : StRcap);
            StAcc1:  state_d = we_q ? StFin : StRcap;
            StRcap:  state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Bus outputs are registered, so their next values follow the state being entered.
    always_comb begin
        busy     = (state_q != StIdle);
        done     = (state_q == StFin);
        m_ai_d   = m_ai_q;
        m_vi_d   = m_vi_q;
        m_we_d   = 1'b0;
        m_bmsk_d = 4'b0000;
        case (state_d)
            StAcc0: begin
                m_ai_d   = addr[ASZ+1:2];
                m_bmsk_d = in_bm8[3:0];
                m_vi_d   = in_d64[DSZ-1:0];
                m_we_d   = we;
            end
            StAcc1: begin
                m_ai_d   = m_ai_q + ASZ'(1);
                m_bmsk_d = bmhi_q;
                m_vi_d   = dhi_q;
                m_we_d   = we_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            sx_q     <= 1'b0;
            split_q  <= 1'b0;
            off_q    <= 2'd0;
            sz_q     <= 2'd0;
            bmhi_q   <= 4'b0000;
            dhi_q    <= '0;
            lo_q     <= '0;
            rdata_q  <= '0;
            m_ai_q   <= '0;
            m_we_q   <= 1'b0;
            m_bmsk_q <= 4'b0000;
            m_vi_q   <= '0;
        end else begin
            m_ai_q   <= m_ai_d;
            m_we_q   <= m_we_d;
            m_bmsk_q <= m_bmsk_d;
            m_vi_q   <= m_vi_d;
            if (state_q == StIdle && req) begin
                we_q    <= we;
                sx_q    <= sx;
                sz_q    <= sz;
                off_q   <= in_off;
                split_q <= in_split;
                bmhi_q  <= in_bm8[7:4];
                dhi_q   <= in_d64[2*DSZ-1:DSZ];
            end
            if (state_q == StAcc1 && !we_q) begin
                lo_q <= m_vo;
            end
            if (state_q == StRcap) begin
                rdata_q <= rd_ext;
            end
        end
    end

    assign rdata  = rdata_q;
    assign m_ai   = m_ai_q;
    assign m_we   = m_we_q;
    assign m_bmsk = m_bmsk_q;
    assign m_vi   = m_vi_q;

endmodule

// File: tb/tb_spram32_bctl.sv
// Scoreboard bench for spram32_bctl with a behavioural 32K x 32 synchronous RAM.
// Expectations adapt to whether SPRAM32_SPLIT_EN is defined.
module tb_spram32_bctl;

    localparam int unsigned ASZ = 15;
`ifdef SPRAM32_SPLIT_EN
    localparam bit SplitEn = 1'b1;
`else
    localparam bit SplitEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic [16:0]   addr = '0;
    logic [1:0]    sz = 2'd0;
    logic          sx = 1'b0;
    logic [31:0]   wdata = '0;
    logic          busy, done, err;
    logic [31:0]   rdata;
    logic [14:0]   m_ai;
    logic          m_we;
    logic [3:0]    m_bmsk;
    logic [31:0]   m_vi;
    logic [31:0]   m_vo;

    logic [31:0]   mem [0:32767];
    int unsigned   cyc = 0;
    int            n_vec = 0;
    int            n_err = 0;

    typedef struct {
        logic [14:0] ai;
        logic        w;
        logic [3:0]  bmsk;
        logic [31:0] vi;
    } beat_t;

    typedef struct {
        int unsigned cyc;
        logic        e;
        logic [31:0] rd;
    } resp_t;

    beat_t bq[$];
    resp_t rq[$];

    spram32_bctl #(.ASZ(ASZ), .DSZ(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .sz     (sz),
        .sx     (sx),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .rdata  (rdata),
        .m_ai   (m_ai),
        .m_we   (m_we),
        .m_bmsk (m_bmsk),
        .m_vi   (m_vi),
        .m_vo   (m_vo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (m_we) begin
            for (int k = 0; k < 4; k++) begin
                if (m_bmsk[k]) mem[m_ai][8*k +: 8] <= m_vi[8*k +: 8];
            end
        end
        m_vo <= mem[m_ai];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] bm);
        return {{8{bm[3]}}, {8{bm[2]}}, {8{bm[1]}}, {8{bm[0]}}};
    endfunction

    task automatic beat(input logic [14:0] ai, input logic w, input logic [3:0] bm,
                        input logic [31:0] vi);
        beat_t b;
        b.ai = ai; b.w = w; b.bmsk = bm; b.vi = vi;
        bq.push_back(b);
    endtask

    // Issues one request at a negedge in IDLE; hold keeps req high into ACC0 to show it is dropped.
    task automatic issue(input logic w, input logic [16:0] a, input logic [1:0] s, input logic x,
                         input logic [31:0] d, input int unsigned lat, input logic e,
                         input logic [31:0] rd, input bit hold);
        resp_t r;
        int    k;
        k = 0;
        while (busy && k < 20) begin @(negedge clk); k++; end
        r.cyc = cyc + lat; r.e = e; r.rd = rd;
        rq.push_back(r);
        req = 1'b1; we = w; addr = a; sz = s; sx = x; wdata = d;
        @(negedge clk);
        if (hold) begin
            addr = 17'h00100;
            @(negedge clk);
        end
        req = 1'b0;
        k = 0;
        while (busy && k < 20) begin @(negedge clk); k++; end
        if (k == 20) check("busy_timeout", 32'(busy), 32'd0);
    endtask

    // Monitor: bus beats and completions are checked against the queued expectations.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_we || m_bmsk != 4'b0000) begin
                if (bq.size() == 0) begin
                    check("bus_unexpected", {27'd0, m_we, m_bmsk}, 32'd0);
                end else begin
                    beat_t b;
                    b = bq.pop_front();
                    check("bus_ai", 32'(m_ai), 32'(b.ai));
                    check("bus_we", 32'(m_we), 32'(b.w));
                    check("bus_bmsk", 32'(m_bmsk), 32'(b.bmsk));
                    if (b.w) check("bus_vi", m_vi & lanes(b.bmsk), b.vi & lanes(b.bmsk));
                end
            end
            if (err && !done) check("err_without_done", 32'(err), 32'd0);
            if (done) begin
                if (rq.size() == 0) begin
                    check("done_unexpected", 32'(done), 32'd0);
                end else begin
                    resp_t r;
                    r = rq.pop_front();
                    check("done_cycle", cyc, r.cyc);
                    check("err", 32'(err), 32'(r.e));
                    check("rdata", rdata, r.rd);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected it to have finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_ctl", {29'd0, busy, done, err}, 32'd0);
        check("rst_bus", {12'd0, m_we, m_bmsk, m_ai}, 32'd0);
        check("rst_vi", m_vi, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Aligned word store and readback
        beat(15'h4, 1'b1, 4'b1111, 32'h11223344);
        issue(1'b1, 17'h10, 2'd2, 1'b0, 32'h11223344, 2, 1'b0, 32'h0, 1'b0);
        beat(15'h4, 1'b0, 4'b1111, 32'h0);
        issue(1'b0, 17'h10, 2'd2, 1'b0, 32'h0, 3, 1'b0, 32'h11223344, 1'b0);

        // Byte store at the top lane; rdata must hold across the store
        beat(15'h4, 1'b1, 4'b1000, 32'hA5000000);
        issue(1'b1, 17'h13, 2'd0, 1'b0, 32'h000000A5, 2, 1'b0, 32'h11223344, 1'b0);
        beat(15'h4, 1'b0, 4'b1000, 32'h0);
        issue(1'b0, 17'h13, 2'd0, 1'b1, 32'h0, 3, 1'b0, 32'hFFFFFFA5, 1'b0);
        beat(15'h4, 1'b0, 4'b1000, 32'h0);
        issue(1'b0, 17'h13, 2'd0, 1'b0, 32'h0, 3, 1'b0, 32'h000000A5, 1'b0);
        beat(15'h4, 1'b0, 4'b1111, 32'h0);
        issue(1'b0, 17'h10, 2'd2, 1'b0, 32'h0, 3, 1'b0, 32'hA5223344, 1'b1);

        // Unaligned non-crossing halves
        beat(15'h4, 1'b0, 4'b1100, 32'h0);
        issue(1'b0, 17'h12, 2'd1, 1'b1, 32'h0, 3, 1'b0, 32'hFFFFA522, 1'b0);
        beat(15'h4, 1'b0, 4'b0110, 32'h0);
        issue(1'b0, 17'h11, 2'd1, 1'b0, 32'h0, 3, 1'b0, 32'h00002233, 1'b0);

        if (SplitEn) begin
            beat(15'h5, 1'b1, 4'b1000, 32'hEF000000);
            beat(15'h6, 1'b1, 4'b0001, 32'h000000BE);
            issue(1'b1, 17'h17, 2'd1, 1'b0, 32'h0000BEEF, 3, 1'b0, 32'h00002233, 1'b0);
            beat(15'h5, 1'b0, 4'b1000, 32'h0);
            beat(15'h6, 1'b0, 4'b0001, 32'h0);
            issue(1'b0, 17'h17, 2'd1, 1'b0, 32'h0, 4, 1'b0, 32'h0000BEEF, 1'b0);
            beat(15'h7FFF, 1'b1, 4'b1100, 32'hF00D0000);
            beat(15'h0000, 1'b1, 4'b0011, 32'h0000CAFE);
            issue(1'b1, 17'h1FFFE, 2'd2, 1'b0, 32'hCAFEF00D, 3, 1'b0, 32'h0000BEEF, 1'b0);
            beat(15'h7FFF, 1'b0, 4'b1100, 32'h0);
            beat(15'h0000, 1'b0, 4'b0011, 32'h0);
            issue(1'b0, 17'h1FFFE, 2'd2, 1'b0, 32'h0, 4, 1'b0, 32'hCAFEF00D, 1'b0);
            beat(15'h0, 1'b0, 4'b1110, 32'h0);
            beat(15'h1, 1'b0, 4'b0001, 32'h0);
            issue(1'b0, 17'h00001, 2'd2, 1'b0, 32'h0, 4, 1'b0, 32'h000000CA, 1'b0);
        end else begin
            issue(1'b1, 17'h17, 2'd1, 1'b0, 32'h0000BEEF, 1, 1'b1, 32'h00002233, 1'b0);
            issue(1'b0, 17'h17, 2'd1, 1'b0, 32'h0, 1, 1'b1, 32'h00002233, 1'b0);
            issue(1'b1, 17'h1FFFE, 2'd2, 1'b0, 32'hCAFEF00D, 1, 1'b1, 32'h00002233, 1'b0);
            issue(1'b0, 17'h00001, 2'd2, 1'b0, 32'h0, 1, 1'b1, 32'h00002233, 1'b0);
            beat(15'h4, 1'b0, 4'b1111, 32'h0);
            issue(1'b0, 17'h10, 2'd2, 1'b0, 32'h0, 3, 1'b0, 32'hA5223344, 1'b0);
        end

        // Asynchronous reset while the store's final bus beat is being presented
        we = 1'b1; sz = 2'd2; sx = 1'b0; wdata = 32'h55667788;
        addr = SplitEn ? 17'h21 : 17'h24;
        if (SplitEn) beat(15'h8, 1'b1, 4'b1110, 32'h66778800);
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        if (SplitEn) begin
            @(posedge clk); #1;
        end
        check("rst_pre_we", 32'(m_we), 32'd1);
        check("rst_pre_ai", 32'(m_ai), 32'h9);
        rst_n = 1'b0;
        #1;
        check("rst_async_we", 32'(m_we), 32'd0);
        check("rst_async_ctl", {28'd0, busy, done, err, m_bmsk != 4'b0000}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_async_rdata", rdata, 32'd0);
        @(negedge clk);

        beat(15'h9, 1'b0, 4'b1111, 32'h0);
        issue(1'b0, 17'h24, 2'd2, 1'b0, 32'h0, 3, 1'b0, 32'h0, 1'b0);
        beat(15'h8, 1'b0, 4'b1111, 32'h0);
        issue(1'b0, 17'h20, 2'd2, 1'b0, 32'h0, 3, 1'b0, SplitEn ? 32'h66778800 : 32'h0, 1'b0);

        repeat (4) @(negedge clk);
        check("resp_queue_drained", 32'(rq.size()), 32'd0);
        check("beat_queue_drained", 32'(bq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
